oled_cmd_queue: RTL

- Multi-channel command/data queue feeding the OLED serial engine.
- Successor to the single-channel serial command buffer. Adds:
  - NUM_CH producers with round-robin arbitration;
  - a D/C flag stored with each entry;
  - a real ready/valid handshake on both sides;
  - an optional drop-on-full mode with a drop counter;
  - level and almost-full status, and a synchronous flush.
- Sits between the drawing/init sequencers (producers) and the SPI serialiser (consumer).

---
 rtl/oled_cmd_queue_if.sv | 25 ++
 rtl/oled_cmd_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/oled_cmd_queue_if.sv
// Producer/consumer handshake bundle for oled_cmd_queue.
// The slave modport is the queue side; master is the producer/consumer environment.
interface oled_cmd_queue_if #(
    parameter int COMMAND_W = 8,
    parameter int NUM_CH    = 2
);
    logic [NUM_CH*COMMAND_W-1:0] in_data;
    logic [NUM_CH-1:0]           in_dc;
    logic [NUM_CH-1:0]           in_valid;
    logic [NUM_CH-1:0]           in_ready;
    logic [COMMAND_W-1:0]        out_data;
    logic                        out_dc;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  in_data, in_dc, in_valid, out_ready,
        output in_ready, out_data, out_dc, out_valid
    );

    modport master (
        output in_data, in_dc, in_valid, out_ready,
        input  in_ready, out_data, out_dc, out_valid
    );
endinterface

// File: rtl/oled_cmd_queue.sv
// Multi-channel round-robin command/data FIFO with D/C flag, optional drop-on-full,
// level/almost-full status and synchronous flush, feeding the OLED serial engine.
module oled_cmd_queue #(
    parameter int DEPTH        = 64,
    parameter int COMMAND_W    = 8,
    parameter int NUM_CH       = 2,
    parameter int DROP_ON_FULL = 0,
    parameter int AFULL_LEVEL  = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    oled_cmd_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic [15:0]              drop_count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int RRW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [COMMAND_W:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic [RRW-1:0]     r_rr_ptr;
    logic [15:0]        r_drop_count;

    logic [NUM_CH-1:0]  w_grant;
    logic [RRW-1:0]     w_grant_idx;
    logic               w_grant_any;
    logic               w_full;
    logic               w_empty;
    logic               w_slot_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_drop;
    logic               w_out_valid;
    logic               w_pop;
    logic [COMMAND_W:0] w_in_word;

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(r_rr_ptr) + k) % NUM_CH;
            if (!w_grant_any && bus.in_valid[idx]) begin
                w_grant_any  = 1'b1;
                w_grant_idx  = RRW'(idx);
                w_grant[idx] = 1'b1;
            end
        end
    end

    assign w_full       = (r_level == LW'(DEPTH));
    assign w_empty      = (r_level == '0);
    assign w_slot_ready = !flush && ((DROP_ON_FULL != 0) || !w_full);
    assign bus.in_ready = w_grant & {NUM_CH{w_slot_ready}};
    assign w_accept     = w_grant_any && w_slot_ready;
    assign w_push       = w_accept && !w_full;
    assign w_drop       = w_accept && w_full;
    assign w_out_valid  = !w_empty && !flush;
    assign w_pop        = w_out_valid && bus.out_ready;
    assign w_in_word    = {bus.in_dc[w_grant_idx],
                           bus.in_data[32'(w_grant_idx)*COMMAND_W +: COMMAND_W]};

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= w_in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_rr_ptr     <= RRW'(NUM_CH - 1);
            r_drop_count <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
            if (w_accept) begin
                r_rr_ptr <= w_grant_idx;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign bus.out_valid               = w_out_valid;
    assign {bus.out_dc, bus.out_data}  = r_mem[r_rd_ptr];
    assign level                       = r_level;
    assign almost_full                 = (r_level >= LW'(AFULL_LEVEL));
    assign drop_count                  = r_drop_count;
endmodule
